vga_sync_monitor: RTL and testbench

//  Downstream checker on the Simple_VGA output bus (hsync, vsync, rgb) in the development-board sim.

---
 rtl/vga_sync_monitor.sv | 242 ++++++++++++++++++++++++
 tb/tb_vga_sync_monitor.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_monitor.sv
// Checks the timing of a VGA sync/pixel bus and CRCs the active picture once per frame.
// Latency: line/frame results are updated 1-2 sys_clk cycles after the registered sync edge.
// Backpressure: none. This is a passive observer and never stalls the bus.
module vga_sync_monitor #(
  parameter bit          SYNC_POL    = 1'b0,
  parameter int unsigned CLK_PER_PIX = 2,
  parameter int unsigned H_START     = 288,
  parameter int unsigned H_ACT       = 640,
  parameter int unsigned V_START     = 35,
  parameter int unsigned V_ACT       = 480,
  parameter int unsigned LOCK_FRAMES = 3
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [15:0] rgb,
  output logic [11:0] h_total,
  output logic [11:0] h_sync_w,
  output logic [11:0] v_total,
  output logic [11:0] v_sync_w,
  output logic [15:0] frame_crc,
  output logic [19:0] frame_pix,
  output logic        frame_done,
  output logic        locked,
  output logic        timing_err
);

  localparam logic [11:0] CNT_MAX    = 12'hFFF;
  localparam logic [11:0] H_ST       = 12'(H_START);
  localparam logic [11:0] H_ACT_W    = 12'(H_ACT);
  localparam logic [11:0] PH_LAST    = 12'(CLK_PER_PIX - 1);
  localparam logic [11:0] V_LO       = 12'(V_START);
  localparam logic [11:0] V_HI       = 12'(V_START + V_ACT);
  localparam logic [7:0]  STABLE_TGT = 8'(LOCK_FRAMES - 1);

  // Registered sync levels, normalised so 1 always means "asserted".
  logic        hs_q, hs_p, vs_q, vs_p;
  // Pixel data is delayed two stages so h_cnt == H_START lines up with the
  // pixel presented H_START clocks after the raw hsync assertion.
  logic [15:0] rgb_q, rgb_qq;

  logic        line_start, frame_start, hs_fall;

  logic [11:0] h_cnt;
  logic [11:0] hs_w;
  logic [11:0] v_cnt;
  logic [11:0] vs_lines;
  logic [11:0] col;
  logic [11:0] ph;
  logic        v_act;
  logic        samp;
  logic        sat_hit;

  logic [15:0] crc_acc;
  logic [19:0] pix_cnt;
  logic        first_seen;

  logic [11:0] prev_ht, prev_hsw, prev_vt, prev_vsw;
  logic        have_prev;
  logic        match;
  logic        mismatch;
  logic [7:0]  stable, stable_nxt;

  // CRC-16-CCITT (poly 0x1021), MSB first, one full 16-bit word per call.
  function automatic logic [15:0] crc16_word(input logic [15:0] crc_in, input logic [15:0] d);
    logic [15:0] c;
    logic        fb;
    c = crc_in;
    for (int i = 15; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  assign line_start  = hs_q & ~hs_p;
  assign frame_start = vs_q & ~vs_p;
  assign hs_fall     = hs_p & ~hs_q;

  // h_cnt is about to step into saturation; this can only happen once per line.
  assign sat_hit = !line_start && (h_cnt == CNT_MAX - 12'd1);

  assign v_act = (v_cnt >= V_LO) && (v_cnt < V_HI);

  // The first pixel of a line is found by position, the rest by the phase counter.
  assign samp = v_act && !line_start && !frame_start && (col != H_ACT_W) &&
                ((col == 12'd0) ? (h_cnt == H_ST) : (ph == PH_LAST));

  assign match = (h_total == prev_ht) && (h_sync_w == prev_hsw) &&
                 (v_total == prev_vt) && (v_sync_w == prev_vsw);

  // Decide the next stable-frame count; saturation and mismatches both restart it.
  always_comb begin
    mismatch   = frame_done && have_prev && !match;
    stable_nxt = stable;
    if (sat_hit || mismatch) begin
      stable_nxt = 8'd0;
    end else if (frame_done && have_prev && (stable != STABLE_TGT)) begin
      stable_nxt = stable + 8'd1;
    end
  end

  // Input register stage: sync levels, their previous values, and delayed pixel data.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hs_q   <= 1'b0;
      hs_p   <= 1'b0;
      vs_q   <= 1'b0;
      vs_p   <= 1'b0;
      rgb_q  <= 16'd0;
      rgb_qq <= 16'd0;
    end else begin
      hs_q   <= (hsync == SYNC_POL);
      hs_p   <= hs_q;
      vs_q   <= (vsync == SYNC_POL);
      vs_p   <= vs_q;
      rgb_q  <= rgb;
      rgb_qq <= rgb_q;
    end
  end

  // Horizontal position, line length and hsync width measurement.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_cnt    <= 12'd0;
      h_total  <= 12'd0;
      hs_w     <= 12'd0;
      h_sync_w <= 12'd0;
    end else begin
      if (line_start) begin
        h_cnt   <= 12'd0;
        h_total <= (h_cnt == CNT_MAX) ? CNT_MAX : h_cnt + 12'd1;
        hs_w    <= 12'd1;
      end else begin
        if (h_cnt != CNT_MAX) h_cnt <= h_cnt + 12'd1;
        if (hs_q && (hs_w != CNT_MAX)) hs_w <= hs_w + 12'd1;
      end
      if (hs_fall) h_sync_w <= hs_w;
    end
  end

  // Line index within the frame and count of line starts seen during vsync.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      v_cnt    <= 12'd0;
      vs_lines <= 12'd0;
    end else if (frame_start) begin
      // A coincident line start belongs to the new frame as line 0.
      v_cnt    <= 12'd0;
      vs_lines <= line_start ? 12'd1 : 12'd0;
    end else if (line_start) begin
      if (v_cnt != CNT_MAX) v_cnt <= v_cnt + 12'd1;
      if (vs_q && (vs_lines != CNT_MAX)) vs_lines <= vs_lines + 12'd1;
    end
  end

  // Pixel column and phase tracking for sample-point selection.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      col <= 12'd0;
      ph  <= 12'd0;
    end else if (line_start) begin
      col <= 12'd0;
      ph  <= 12'd0;
    end else if (samp) begin
      col <= col + 12'd1;
      ph  <= 12'd0;
    end else if ((col != 12'd0) && (ph != CNT_MAX)) begin
      ph  <= ph + 12'd1;
    end
  end

  // Running CRC and pixel count of the current frame's active area.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      crc_acc <= 16'hFFFF;
      pix_cnt <= 20'd0;
    end else if (frame_start) begin
      crc_acc <= 16'hFFFF;
      pix_cnt <= 20'd0;
    end else if (samp) begin
      crc_acc <= crc16_word(crc_acc, rgb_qq);
      pix_cnt <= pix_cnt + 20'd1;
    end
  end

  // Publish the finished frame at each vsync edge except the first after reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      first_seen <= 1'b0;
      v_total    <= 12'd0;
      v_sync_w   <= 12'd0;
      frame_crc  <= 16'd0;
      frame_pix  <= 20'd0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (frame_start) begin
        first_seen <= 1'b1;
        if (first_seen) begin
          v_total    <= (v_cnt == CNT_MAX) ? CNT_MAX : v_cnt + 12'd1;
          v_sync_w   <= vs_lines;
          frame_crc  <= crc_acc;
          frame_pix  <= pix_cnt;
          frame_done <= 1'b1;
        end
      end
    end
  end

  // Compare each published frame against the previous one and track lock.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      prev_ht    <= 12'd0;
      prev_hsw   <= 12'd0;
      prev_vt    <= 12'd0;
      prev_vsw   <= 12'd0;
      have_prev  <= 1'b0;
      stable     <= 8'd0;
      locked     <= 1'b0;
      timing_err <= 1'b0;
    end else begin
      stable     <= stable_nxt;
      timing_err <= sat_hit || mismatch;
      if (frame_done) begin
        prev_ht   <= h_total;
        prev_hsw  <= h_sync_w;
        prev_vt   <= v_total;
        prev_vsw  <= v_sync_w;
        have_prev <= 1'b1;
      end
      if (sat_hit || mismatch) begin
        locked <= 1'b0;
      end else if (frame_done && have_prev) begin
        locked <= (stable_nxt >= STABLE_TGT);
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Bench for vga_sync_monitor on a scaled-down raster (40-clk lines, 12-line frames).
// Two instances run in lockstep: active-low syncs and inverted syncs with SYNC_POL=1.
// Frame expectations are queued as frames are driven and checked at each frame_done.
module tb_vga_sync_monitor;

  localparam int H_TOT   = 40;
  localparam int H_SW    = 6;
  localparam int V_TOT   = 12;
  localparam int V_SW    = 2;
  localparam int H_START = 12;
  localparam int H_ACT   = 10;
  localparam int CPP     = 2;
  localparam int V_START = 4;
  localparam int V_ACT   = 5;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        hsync, vsync;
  logic [15:0] rgb;

  logic [11:0] h_total_o  [2];
  logic [11:0] h_sync_w_o [2];
  logic [11:0] v_total_o  [2];
  logic [11:0] v_sync_w_o [2];
  logic [15:0] frame_crc_o[2];
  logic [19:0] frame_pix_o[2];
  logic        frame_done_o[2];
  logic        locked_o   [2];
  logic        timing_err_o[2];

  typedef struct {
    logic [11:0] ht, hsw, vt, vsw;
    logic [15:0] crc;
    logic [19:0] pix;
    logic        lock;
    logic        err;
  } exp_t;

  typedef struct {
    int          pat;
    int          last_len;
    bit          corrupt;
    logic [11:0] exp_ht;
    bit          exp_lock;
    bit          exp_err;
  } vec_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   fd_count = 0;
  int   err_pulses = 0;
  bit   lock_pend = 0;
  int   fnum = 0;
  logic [15:0] m_crc;

  always #5 sys_clk = ~sys_clk;

  vga_sync_monitor #(
    .SYNC_POL(1'b0), .CLK_PER_PIX(CPP), .H_START(H_START), .H_ACT(H_ACT),
    .V_START(V_START), .V_ACT(V_ACT), .LOCK_FRAMES(3)
  ) dut0 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .h_total(h_total_o[0]), .h_sync_w(h_sync_w_o[0]), .v_total(v_total_o[0]),
    .v_sync_w(v_sync_w_o[0]), .frame_crc(frame_crc_o[0]), .frame_pix(frame_pix_o[0]),
    .frame_done(frame_done_o[0]), .locked(locked_o[0]), .timing_err(timing_err_o[0])
  );

  vga_sync_monitor #(
    .SYNC_POL(1'b1), .CLK_PER_PIX(CPP), .H_START(H_START), .H_ACT(H_ACT),
    .V_START(V_START), .V_ACT(V_ACT), .LOCK_FRAMES(3)
  ) dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .hsync(~hsync), .vsync(~vsync), .rgb(rgb),
    .h_total(h_total_o[1]), .h_sync_w(h_sync_w_o[1]), .v_total(v_total_o[1]),
    .v_sync_w(v_sync_w_o[1]), .frame_crc(frame_crc_o[1]), .frame_pix(frame_pix_o[1]),
    .frame_done(frame_done_o[1]), .locked(locked_o[1]), .timing_err(timing_err_o[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Byte-wise CRC-16-CCITT reference (high byte first).
  function automatic logic [15:0] crc_word(input logic [15:0] c_in, input logic [15:0] d);
    logic [15:0] c;
    logic [7:0]  b;
    c = c_in;
    for (int n = 0; n < 2; n++) begin
      b = (n == 0) ? d[15:8] : d[7:0];
      c = c ^ {b, 8'h00};
      for (int i = 0; i < 8; i++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  function automatic logic [15:0] pix_val(input int pat, input int f, input int line,
                                          input int k, input bit corrupt);
    logic [15:0] v;
    if (pat == 0) v = 16'h0000;
    else          v = 16'(f * 4099 + line * 97 + k * 13) ^ 16'h5A00;
    if (corrupt && line == V_START + 1 && k == 3) v = v ^ 16'h0001;
    return v;
  endfunction

  task automatic drive_cycle(input bit hs, input bit vs, input logic [15:0] d);
    @(negedge sys_clk);
    hsync = ~hs;
    vsync = ~vs;
    rgb   = d;
  endtask

  task automatic drive_line(input int len, input bit vs, input int line, input int pat,
                            input int f, input bit corrupt, input bit chk_sat);
    logic [15:0] d;
    int k;
    for (int c = 0; c < len; c++) begin
      d = 16'hA5A5;
      k = (c - H_START) / CPP;
      if (line >= V_START && line < V_START + V_ACT && c >= H_START &&
          ((c - H_START) % CPP) == 0 && k < H_ACT) begin
        d     = pix_val(pat, f, line, k, corrupt);
        m_crc = crc_word(m_crc, d);
      end
      drive_cycle(c < H_SW, vs, d);
      if (chk_sat && c == 4) begin
        chk("sat_h_total0", 32'(h_total_o[0]), 32'd4095);
        chk("sat_h_total1", 32'(h_total_o[1]), 32'd4095);
      end
    end
  endtask

  task automatic drive_frame(input int pat, input bit corrupt, input int stretch_line,
                             input int stretch_len, input int last_len, input int n_lines,
                             input bit push, input logic [11:0] exp_ht, input bit exp_lock,
                             input bit exp_err);
    int len;
    m_crc = 16'hFFFF;
    for (int l = 0; l < n_lines; l++) begin
      len = (l == stretch_line) ? stretch_len : ((l == V_TOT - 1) ? last_len : H_TOT);
      drive_line(len, l < V_SW, l, pat, fnum, corrupt,
                 (l == stretch_line + 1) && (stretch_len > 4095));
    end
    if (push)
      exp_q.push_back('{exp_ht, 12'(H_SW), 12'(V_TOT), 12'(V_SW), m_crc,
                        20'(V_ACT * H_ACT), exp_lock, exp_err});
    fnum++;
  endtask

  task automatic check_reset(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_h_total"},  32'(h_total_o[d]), 32'd0);
      chk({tag, "_h_sync_w"}, 32'(h_sync_w_o[d]), 32'd0);
      chk({tag, "_v_total"},  32'(v_total_o[d]), 32'd0);
      chk({tag, "_v_sync_w"}, 32'(v_sync_w_o[d]), 32'd0);
      chk({tag, "_crc"},      32'(frame_crc_o[d]), 32'd0);
      chk({tag, "_pix"},      32'(frame_pix_o[d]), 32'd0);
      chk({tag, "_done"},     32'(frame_done_o[d]), 32'd0);
      chk({tag, "_locked"},   32'(locked_o[d]), 32'd0);
      chk({tag, "_err"},      32'(timing_err_o[d]), 32'd0);
    end
  endtask

  // Scoreboard: pop an expectation at each frame_done, then check lock/err one cycle later.
  always @(posedge sys_clk) begin
    #1;
    if (sys_rst_n) begin
      if (timing_err_o[0]) err_pulses++;
      if (lock_pend) begin
        lock_pend = 0;
        for (int d = 0; d < 2; d++) begin
          chk($sformatf("locked[%0d]", d), 32'(locked_o[d]), 32'(cur.lock));
          chk($sformatf("timing_err[%0d]", d), 32'(timing_err_o[d]), 32'(cur.err));
        end
      end
      if (frame_done_o[0] || frame_done_o[1]) begin
        fd_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame_done: got pulse expected none");
        end else begin
          cur = exp_q.pop_front();
          for (int d = 0; d < 2; d++) begin
            chk($sformatf("frame_done[%0d]", d), 32'(frame_done_o[d]), 32'd1);
            chk($sformatf("h_total[%0d]", d),    32'(h_total_o[d]),   32'(cur.ht));
            chk($sformatf("h_sync_w[%0d]", d),   32'(h_sync_w_o[d]),  32'(cur.hsw));
            chk($sformatf("v_total[%0d]", d),    32'(v_total_o[d]),   32'(cur.vt));
            chk($sformatf("v_sync_w[%0d]", d),   32'(v_sync_w_o[d]),  32'(cur.vsw));
            chk($sformatf("frame_crc[%0d]", d),  32'(frame_crc_o[d]), 32'(cur.crc));
            chk($sformatf("frame_pix[%0d]", d),  32'(frame_pix_o[d]), 32'(cur.pix));
          end
          lock_pend = 1;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    int   err_base;
    int   fd_base;

    // {pattern, last line length, corrupt, expected h_total, locked, timing_err}
    vecs[0] = '{0, 40, 1'b0, 12'd40, 1'b0, 1'b0};
    vecs[1] = '{0, 40, 1'b0, 12'd40, 1'b0, 1'b0};
    vecs[2] = '{0, 40, 1'b0, 12'd40, 1'b1, 1'b0};
    vecs[3] = '{0, 40, 1'b1, 12'd40, 1'b1, 1'b0};
    vecs[4] = '{1, 40, 1'b0, 12'd40, 1'b1, 1'b0};
    vecs[5] = '{1, 42, 1'b0, 12'd42, 1'b0, 1'b1};
    vecs[6] = '{1, 40, 1'b0, 12'd40, 1'b0, 1'b1};
    vecs[7] = '{1, 40, 1'b0, 12'd40, 1'b0, 1'b0};
    vecs[8] = '{1, 40, 1'b0, 12'd40, 1'b1, 1'b0};

    sys_rst_n = 1'b0;
    hsync     = 1'b1;
    vsync     = 1'b1;
    rgb       = 16'h0000;
    repeat (3) @(negedge sys_clk);
    check_reset("rst");
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);

    // Nominal, constant-zero, single corrupted pixel, ramp, and one long last line.
    for (int i = 0; i < 9; i++)
      drive_frame(vecs[i].pat, vecs[i].corrupt, -1, 0, vecs[i].last_len, V_TOT, 1'b1,
                  vecs[i].exp_ht, vecs[i].exp_lock, vecs[i].exp_err);

    // hsync stops for longer than the counter range in the middle of a frame.
    err_base = err_pulses;
    drive_frame(1, 1'b0, 5, 4200, H_TOT, V_TOT, 1'b1, 12'd40, 1'b0, 1'b0);
    drive_frame(1, 1'b0, -1, 0, H_TOT, V_TOT, 1'b1, 12'd40, 1'b1, 1'b0);
    drive_frame(1, 1'b0, -1, 0, H_TOT, 6, 1'b0, 12'd0, 1'b0, 1'b0);
    chk("sat_err_pulses", 32'(err_pulses - err_base), 32'd1);

    // Reset in the middle of a frame, then restart.
    #2 sys_rst_n = 1'b0;
    #1 check_reset("midrst");
    repeat (3) drive_cycle(1'b0, 1'b0, 16'h0000);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    fd_base = fd_count;
    drive_frame(1, 1'b0, -1, 0, H_TOT, V_TOT, 1'b1, 12'd40, 1'b0, 1'b0);
    chk("no_done_first_edge", 32'(fd_count - fd_base), 32'd0);
    drive_frame(0, 1'b0, -1, 0, H_TOT, V_TOT, 1'b1, 12'd40, 1'b0, 1'b0);
    drive_frame(0, 1'b0, -1, 0, H_TOT, 2, 1'b0, 12'd0, 1'b0, 1'b0);
    repeat (10) @(negedge sys_clk);
    chk("done_after_reset", 32'(fd_count - fd_base), 32'd2);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
